// File: rtl/cpc_io_snoop_if.sv
// Z80 I/O bus as seen by the snooper: strobes, upper address bits and data.
interface cpc_io_snoop_if;
   logic       ioreq_b;
   logic       wr_b;
   logic       m1_b;
   logic       adr15;
   logic       adr14;
   logic       adr13;
   logic [7:0] data;

   modport master (
      output ioreq_b, wr_b, m1_b, adr15, adr14, adr13, data
   );

   modport slave (
      input ioreq_b, wr_b, m1_b, adr15, adr14, adr13, data
   );
endinterface

// File: rtl/cpc_io_snoop.sv
// Passive CPC I/O write snooper: tracks the ROM select port (DFxx) and the
// gate-array ROM enable bits from filtered Z80 OUT cycles.
module cpc_io_snoop #(
   parameter int unsigned FILTER_CYCLES = 2,
   parameter logic [7:0]  RESET_ROMSEL  = 8'h00
) (
   input  logic               clk,
   input  logic               reset_b,
   cpc_io_snoop_if.slave      bus,
   output logic [7:0]         romsel,
   output logic               romsel_wr,
   output logic               lrom_en,
   output logic               urom_en,
   output logic               ga_wr
);

   localparam logic [2:0] FILT = 3'(FILTER_CYCLES);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      QUAL     = 2'd1,
      WAIT_END = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] sync1_q, sync1_d;   // {m1_b, wr_b, ioreq_b}
   logic [2:0] sync2_q, sync2_d;
   logic [7:0] romsel_q, romsel_d;
   logic       romsel_wr_q, romsel_wr_d;
   logic       lrom_en_q, lrom_en_d;
   logic       urom_en_q, urom_en_d;
   logic       ga_wr_q, ga_wr_d;
   logic       io_wr_s;
   logic       capture_s;

   assign io_wr_s = ~sync2_q[0] & ~sync2_q[1] & sync2_q[2];

   // Next-state logic: synchronisers, qualification FSM and capture decode.
   always_comb begin
      sync1_d     = {bus.m1_b, bus.wr_b, bus.ioreq_b};
      sync2_d     = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      capture_s   = 1'b0;
      romsel_d    = romsel_q;
      romsel_wr_d = 1'b0;
      lrom_en_d   = lrom_en_q;
      urom_en_d   = urom_en_q;
      ga_wr_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (io_wr_s) begin
               cnt_d = 3'd1;
               if (FILT == 3'd1) begin
                  capture_s = 1'b1;
                  state_d   = WAIT_END;
               end else begin
                  state_d = QUAL;
               end
            end else begin
               cnt_d = 3'd0;
            end
         end
         QUAL: begin
            if (io_wr_s) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_d == FILT) begin
                  capture_s = 1'b1;
                  state_d   = WAIT_END;
               end else begin
                  state_d = QUAL;
               end
            end else begin
               // Strobe vanished before qualifying: treat as a glitch.
               cnt_d   = 3'd0;
               state_d = IDLE;
            end
         end
         WAIT_END: begin
            if (!io_wr_s) begin
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               state_d = WAIT_END;
            end
         end
         default: begin
            cnt_d   = 3'd0;
            state_d = IDLE;
         end
      endcase

      // Address and data are stable for the whole cycle, so they are used raw.
      if (capture_s) begin
         if (bus.adr15 && bus.adr14 && !bus.adr13) begin
            romsel_d    = bus.data;
            romsel_wr_d = 1'b1;
         end else if (!bus.adr15 && bus.adr14 && (bus.data[7:6] == 2'b10)) begin
            lrom_en_d = ~bus.data[2];
            urom_en_d = ~bus.data[3];
            ga_wr_d   = 1'b1;
         end else begin
            romsel_d = romsel_q;
         end
      end else begin
         romsel_d = romsel_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sync1_q     <= 3'b111;
         sync2_q     <= 3'b111;
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         romsel_q    <= RESET_ROMSEL;
         romsel_wr_q <= 1'b0;
         lrom_en_q   <= 1'b1;
         urom_en_q   <= 1'b1;
         ga_wr_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         romsel_q    <= romsel_d;
         romsel_wr_q <= romsel_wr_d;
         lrom_en_q   <= lrom_en_d;
         urom_en_q   <= urom_en_d;
         ga_wr_q     <= ga_wr_d;
      end
   end

   assign romsel    = romsel_q;
   assign romsel_wr = romsel_wr_q;
   assign lrom_en   = lrom_en_q;
   assign urom_en   = urom_en_q;
   assign ga_wr     = ga_wr_q;

endmodule

// File: tb/tb_cpc_io_snoop.sv
// Bench for cpc_io_snoop: directed OUT cycles plus randomized writes checked
// cycle by cycle against a transaction-level model of the snooper.
module tb_cpc_io_snoop;

   localparam int F = 2;

   logic       clk = 1'b0;
   logic       reset_b = 1'b0;
   logic [7:0] romsel;
   logic       romsel_wr, lrom_en, urom_en, ga_wr;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] m_romsel = 8'h00;
   logic       m_lrom   = 1'b1;
   logic       m_urom   = 1'b1;

   cpc_io_snoop_if bus ();

   cpc_io_snoop #(.FILTER_CYCLES(F), .RESET_ROMSEL(8'h00)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .bus       (bus),
      .romsel    (romsel),
      .romsel_wr (romsel_wr),
      .lrom_en   (lrom_en),
      .urom_en   (urom_en),
      .ga_wr     (ga_wr)
   );

   always #5 clk = ~clk;

   task automatic bus_idle();
      bus.ioreq_b = 1'b1;
      bus.wr_b    = 1'b1;
      bus.m1_b    = 1'b1;
   endtask

   // Drives an I/O cycle at a falling edge; the next rising edge is E0.
   task automatic start_write(input logic [2:0] adr, input logic [7:0] d, input logic m1n);
      @(negedge clk);
      bus.adr15   = adr[2];
      bus.adr14   = adr[1];
      bus.adr13   = adr[0];
      bus.data    = d;
      bus.m1_b    = m1n;
      bus.ioreq_b = 1'b0;
      bus.wr_b    = 1'b0;
   endtask

   // Strobes are already low; next rising edge is E0. Raw strobe stays low for
   // len edges. A write is captured iff it is not an INTA and the strobe
   // lasts at least F samples; the capture lands at edge E0+1+F.
   task automatic run_cycles(input string name, input int len, input logic m1n,
                             input logic [2:0] adr, input logic [7:0] d,
                             input int chg_k, input logic [7:0] chg_d);
      bit cap, is_rom, is_ga;
      int c, kmax;
      logic [7:0] e_rs;
      logic e_l, e_u, e_rw, e_gw;
      cap    = m1n && (len >= F);
      is_rom = (adr == 3'b110);
      is_ga  = (adr[2:1] == 2'b01) && (d[7:6] == 2'b10);
      c      = 1 + F;
      kmax   = ((len > c) ? len : c) + 4;
      for (int k = 0; k <= kmax; k++) begin
         @(negedge clk);
         e_rs = (cap && is_rom && k >= c) ? d : m_romsel;
         e_rw = cap && is_rom && (k == c);
         e_l  = (cap && is_ga && k >= c) ? ~d[2] : m_lrom;
         e_u  = (cap && is_ga && k >= c) ? ~d[3] : m_urom;
         e_gw = cap && is_ga && (k == c);
         vectors += 5;
         if (romsel !== e_rs) begin
            errors++;
            $display("FAIL %s k=%0d romsel got %h exp %h", name, k, romsel, e_rs);
         end
         if (romsel_wr !== e_rw) begin
            errors++;
            $display("FAIL %s k=%0d romsel_wr got %b exp %b", name, k, romsel_wr, e_rw);
         end
         if (lrom_en !== e_l) begin
            errors++;
            $display("FAIL %s k=%0d lrom_en got %b exp %b", name, k, lrom_en, e_l);
         end
         if (urom_en !== e_u) begin
            errors++;
            $display("FAIL %s k=%0d urom_en got %b exp %b", name, k, urom_en, e_u);
         end
         if (ga_wr !== e_gw) begin
            errors++;
            $display("FAIL %s k=%0d ga_wr got %b exp %b", name, k, ga_wr, e_gw);
         end
         if (k + 1 == len) bus_idle();
         if (k == chg_k) bus.data = chg_d;
      end
      if (cap && is_rom) m_romsel = d;
      if (cap && is_ga) begin
         m_lrom = ~d[2];
         m_urom = ~d[3];
      end
   endtask

   task automatic write(input string name, input logic [2:0] adr, input logic [7:0] d,
                        input int len, input logic m1n);
      start_write(adr, d, m1n);
      run_cycles(name, len, m1n, adr, d, -1, 8'h00);
   endtask

   task automatic test_reset();
      bus_idle();
      bus.adr15 = 1'b0;
      bus.adr14 = 1'b0;
      bus.adr13 = 1'b0;
      bus.data  = 8'h00;
      reset_b   = 1'b0;
      repeat (3) @(negedge clk);
      vectors += 5;
      if (romsel !== 8'h00) begin errors++; $display("FAIL reset romsel got %h exp 00", romsel); end
      if (romsel_wr !== 1'b0) begin errors++; $display("FAIL reset romsel_wr got %b exp 0", romsel_wr); end
      if (lrom_en !== 1'b1) begin errors++; $display("FAIL reset lrom_en got %b exp 1", lrom_en); end
      if (urom_en !== 1'b1) begin errors++; $display("FAIL reset urom_en got %b exp 1", urom_en); end
      if (ga_wr !== 1'b0) begin errors++; $display("FAIL reset ga_wr got %b exp 0", ga_wr); end
      reset_b = 1'b1;
      repeat (3) @(negedge clk);
      vectors += 2;
      if (romsel !== 8'h00) begin errors++; $display("FAIL post_reset romsel got %h exp 00", romsel); end
      if (romsel_wr !== 1'b0 || ga_wr !== 1'b0) begin
         errors++;
         $display("FAIL post_reset strobes got %b%b exp 00", romsel_wr, ga_wr);
      end
   endtask

   task automatic test_romsel();
      write("rom_df05", 3'b110, 8'h05, 10, 1'b1);
   endtask

   task automatic test_gate_array();
      write("ga_8c", 3'b011, 8'h8C, 4, 1'b1);
      write("ga_80", 3'b011, 8'h80, 4, 1'b1);
      write("ga_8c_min", 3'b010, 8'h8C, F, 1'b1);
   endtask

   task automatic test_glitch();
      write("glitch_aa", 3'b110, 8'hAA, 1, 1'b1);
      write("rom_min", 3'b110, 8'h3C, F, 1'b1);
   endtask

   task automatic test_no_capture();
      write("inta_df", 3'b110, 8'h55, 6, 1'b0);
      write("ga_c4", 3'b011, 8'hC4, 5, 1'b1);
      write("nomatch", 3'b100, 8'h99, 5, 1'b1);
   endtask

   // Holding the strobe low across a data change must not yield a second capture.
   task automatic test_back_to_back();
      start_write(3'b110, 8'h21, 1'b1);
      run_cycles("b2b", 12, 1'b1, 3'b110, 8'h21, F + 3, 8'h33);
   endtask

   task automatic test_reset_mid(input int len_after);
      start_write(3'b110, 8'h07, 1'b1);
      repeat (3) @(negedge clk);
      reset_b = 1'b0;
      #1;
      m_romsel = 8'h00;
      m_lrom   = 1'b1;
      m_urom   = 1'b1;
      vectors += 3;
      if (romsel !== 8'h00) begin errors++; $display("FAIL rst_mid romsel got %h exp 00", romsel); end
      if (lrom_en !== 1'b1 || urom_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid rom_en got %b%b exp 11", lrom_en, urom_en);
      end
      if (romsel_wr !== 1'b0 || ga_wr !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid strobes got %b%b exp 00", romsel_wr, ga_wr);
      end
      @(negedge clk);
      reset_b = 1'b1;
      run_cycles("rst_resume", len_after, 1'b1, 3'b110, 8'h07, -1, 8'h00);
   endtask

   task automatic test_random();
      logic [2:0] adr;
      logic [7:0] d;
      int len;
      logic m1n;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0:       adr = 3'b110;
            1:       adr = {2'b01, 1'($urandom_range(0, 1))};
            default: adr = 3'($urandom_range(0, 7));
         endcase
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) d[7:6] = 2'b10;
         len = $urandom_range(1, 6);
         m1n = ($urandom_range(0, 7) != 0);
         write("random", adr, d, len, m1n);
      end
   endtask

   initial begin
      test_reset();
      test_romsel();
      test_gate_array();
      test_glitch();
      test_no_capture();
      test_back_to_back();
      test_reset_mid(1);
      test_reset_mid(F);
      test_reset_mid(6);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
